// File: rtl/squeeze_output_unit.sv
// rtl/squeeze_output_unit.sv - SHAKE squeeze output stage (optional SQUEEZE_ZERO_TAIL_EN zeroes unused tail bytes)
`timescale 1ns/1ps
module squeeze_output_unit #(
  parameter int w            = 64,
  parameter int w_byte_size  = 8,
  parameter int w_byte_width = 3,
  parameter int LEN_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    shake_mode,
  input  logic [LEN_W-1:0]        output_len,
  input  logic                    perm_done,
  output logic                    perm_req,
  output logic [4:0]              state_rd_addr,
  input  logic [w-1:0]            state_rd_data,
  output logic [w-1:0]            data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic [w_byte_width:0]   data_out_bytes,
  output logic                    last_out,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_PERM = 2'd1,
    ST_READ      = 2'd2,
    ST_EMIT      = 2'd3
  } state_t;

  localparam logic [4:0]            RATE_128   = 5'd21;
  localparam logic [4:0]            RATE_256   = 5'd17;
  localparam logic [w_byte_width:0] FULL_BYTES = (w_byte_width + 1)'(w_byte_size);
  localparam logic [LEN_W-1:0]      FULL_LEN   = LEN_W'(w_byte_size);

  state_t                  state;
  logic [LEN_W-1:0]        rem_bytes;
  logic [4:0]              word_idx;
  logic [4:0]              rate_words;

  logic                    next_last;
  logic [w_byte_width:0]   next_bytes;
  logic [w-1:0]            masked_word;

  // Byte count and final-word flag for the word about to be emitted
  always_comb begin
    next_last  = (rem_bytes <= FULL_LEN);
    next_bytes = next_last ? rem_bytes[w_byte_width:0] : FULL_BYTES;
  end

  // The read address always follows the word index; it is only updated on a handshake or start
  assign state_rd_addr = word_idx;

  // Squeeze control: length/index bookkeeping, permutation requests and registered stream flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rem_bytes      <= '0;
      word_idx       <= '0;
      rate_words     <= '0;
      perm_req       <= 1'b0;
      data_out_valid <= 1'b0;
      data_out_bytes <= '0;
      last_out       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      perm_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && (output_len != '0)) begin
            rem_bytes  <= output_len;
            rate_words <= shake_mode ? RATE_256 : RATE_128;
            word_idx   <= '0;
            busy       <= 1'b1;
            state      <= ST_WAIT_PERM;
          end
        end
        ST_WAIT_PERM: begin
          if (perm_done) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          data_out_valid <= 1'b1;
          data_out_bytes <= next_bytes;
          last_out       <= next_last;
          state          <= ST_EMIT;
        end
        ST_EMIT: begin
          if (data_out_ready) begin
            data_out_valid <= 1'b0;
            data_out_bytes <= '0;
            last_out       <= 1'b0;
            rem_bytes      <= rem_bytes - LEN_W'(data_out_bytes);
            if (last_out) begin
              // Final word: no permutation request even at a rate-block boundary
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (word_idx == (rate_words - 5'd1)) begin
              perm_req <= 1'b1;
              word_idx <= '0;
              state    <= ST_WAIT_PERM;
            end else begin
              word_idx <= word_idx + 5'd1;
              state    <= ST_READ;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output word: raw state word, or with the unused low-order bytes zeroed when the tail option is built in
  always_comb begin
    masked_word = state_rd_data;
`ifdef SQUEEZE_ZERO_TAIL_EN
    for (int k = 0; k < w_byte_size; k++) begin
      if (k >= int'(data_out_bytes)) begin
        masked_word[w-1-8*k -: 8] = 8'h00;
      end
    end
`endif
    data_out = data_out_valid ? masked_word : '0;
  end

endmodule
